// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one difference bit per clock, LSB first,
// with a registered borrow; operands in and result out over valid/ready.
//
// state  | meaning
// S_IDLE | waiting for operands, start_ready_out=1
// S_RUN  | shifting one difference bit per clock
// S_DONE | result presented, waiting for done_ready_in
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             start_valid_in,
  output logic             start_ready_out,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] diff_out,
  output logic             borrow_out,
  output logic             done_valid_out,
  input  logic             done_ready_in
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_diff;
  logic             r_br;
  logic             r_borrow;
  logic [CW-1:0]    r_cnt;

  logic w_start;
  logic w_run;
  logic w_last;
  logic w_a_bit;
  logic w_b_bit;
  logic w_d;
  logic w_br_nxt;

  // Operand registers shift right, so bit k of each operand is at [0] on RUN edge k.
  assign w_a_bit  = r_a[0];
  assign w_b_bit  = r_b[0];
  assign w_d      = w_a_bit ^ w_b_bit ^ r_br;
  assign w_br_nxt = (~w_a_bit & w_b_bit) | (~(w_a_bit ^ w_b_bit) & r_br);
  assign w_last   = (r_cnt == CW'(WIDTH - 1));
  assign w_run    = (r_state == S_RUN);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_start         = 1'b0;
    start_ready_out = 1'b0;
    done_valid_out  = 1'b0;
    case (r_state)
      S_IDLE: begin
        start_ready_out = 1'b1;
        if (start_valid_in) begin
          w_start     = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done_valid_out = 1'b1;
        if (done_ready_in) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_a      <= '0;
      r_b      <= '0;
      r_diff   <= '0;
      r_br     <= 1'b0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
    end else if (w_start) begin
      r_a   <= a_in;
      r_b   <= b_in;
      r_br  <= 1'b0;
      r_cnt <= '0;
    end else if (w_run) begin
      r_a    <= r_a >> 1;
      r_b    <= r_b >> 1;
      r_br   <= w_br_nxt;
      r_diff <= {w_d, r_diff[WIDTH-1:1]};
      r_cnt  <= r_cnt + 1'b1;
      if (w_last) begin
        r_borrow <= w_br_nxt;
      end
    end
  end

  assign diff_out   = r_diff;
  assign borrow_out = r_borrow;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: four instances (WIDTH 8, 2, 13, 32) checked every
// cycle against an arithmetic reference, plus directed cases on the 8-bit one.
module tb_serial_subtractor;

  localparam int NI = 4;

  function automatic int width_of(input int i);
    case (i)
      0:       return 8;
      1:       return 2;
      2:       return 13;
      default: return 32;
    endcase
  endfunction

  function automatic logic [63:0] mask_of(input int w);
    if (w >= 64) return '1;
    return (64'd1 << w) - 64'd1;
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_s [NI];
  logic        sv_s  [NI];
  logic        dr_s  [NI];
  logic [63:0] a_s   [NI];
  logic [63:0] b_s   [NI];
  logic        rdy_s [NI];
  logic        dv_s  [NI];
  logic        bo_s  [NI];
  logic [63:0] d_s   [NI];

  int   pass_cnt  = 0;
  int   total_cnt = 0;
  logic go        = 1'b0;

  function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    else pass_cnt++;
  endfunction

  function automatic void timeout(input string nm);
    total_cnt++;
    $display("FAIL %s: wait bound expired at %0t", nm, $time);
  endfunction

  for (genvar G = 0; G < NI; G++) begin : g_inst
    localparam int W = width_of(G);
    logic [W-1:0] w_diff;
    logic         fin = 1'b0;

    serial_subtractor #(.WIDTH(W)) u_dut (
      .clk_in          (clk),
      .rst_n_in        (rst_s[G]),
      .start_valid_in  (sv_s[G]),
      .start_ready_out (rdy_s[G]),
      .a_in            (a_s[G][W-1:0]),
      .b_in            (b_s[G][W-1:0]),
      .diff_out        (w_diff),
      .borrow_out      (bo_s[G]),
      .done_valid_out  (dv_s[G]),
      .done_ready_in   (dr_s[G])
    );
    assign d_s[G] = 64'(w_diff);

    if (G > 0) begin : g_rnd
      initial begin
        wait (go);
        run_random(G, 250);
        fin = 1'b1;
      end
    end
  end

  // Reference: one op in flight per instance; result due WIDTH edges after acceptance.
  longint      cyc = 0;
  logic        busy [NI];
  longint      t0   [NI];
  logic [63:0] ed   [NI];
  logic        eb   [NI];

  always @(posedge clk) begin
    cyc++;
    for (int g = 0; g < NI; g++) begin
      logic [63:0] m, am, bm;
      logic vpre, rpre;
      if (rst_s[g] !== 1'b1) begin
        busy[g] = 1'b0;
      end else begin
        m    = mask_of(width_of(g));
        vpre = busy[g] && (cyc > t0[g] + width_of(g));
        rpre = !busy[g];
        if (vpre && dr_s[g]) busy[g] = 1'b0;
        if (rpre && sv_s[g]) begin
          am      = a_s[g] & m;
          bm      = b_s[g] & m;
          ed[g]   = (am - bm) & m;
          eb[g]   = (am < bm);
          t0[g]   = cyc;
          busy[g] = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int g = 0; g < NI; g++) begin
      logic ev;
      if (rst_s[g] === 1'b1 && cyc > 0) begin
        ev = busy[g] && (cyc >= t0[g] + width_of(g));
        check($sformatf("i%0d_done_valid", g), 64'(dv_s[g]), 64'(ev));
        check($sformatf("i%0d_start_ready", g), 64'(rdy_s[g]), 64'(!busy[g]));
        if (ev) begin
          check($sformatf("i%0d_diff", g), d_s[g], ed[g]);
          check($sformatf("i%0d_borrow", g), 64'(bo_s[g]), 64'(eb[g]));
        end
      end
    end
  end

  task automatic start_op(input int i, input logic [63:0] a, input logic [63:0] b);
    int n = 0;
    while (rdy_s[i] !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (rdy_s[i] !== 1'b1) timeout($sformatf("i%0d_start_wait", i));
    a_s[i]  = a;
    b_s[i]  = b;
    sv_s[i] = 1'b1;
    @(posedge clk); #1;
    sv_s[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, output int lat);
    lat = 0;
    while (dv_s[i] !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    if (dv_s[i] !== 1'b1) timeout($sformatf("i%0d_done_wait", i));
  endtask

  task automatic finish_op(input int i, input int stall);
    dr_s[i] = 1'b0;
    repeat (stall) begin
      @(posedge clk); #1;
    end
    dr_s[i] = 1'b1;
    @(posedge clk); #1;
    dr_s[i] = 1'b0;
  endtask

  task automatic do_op(input int i, input logic [63:0] a, input logic [63:0] b, input int stall,
                       output int lat, output logic [63:0] d, output logic br);
    start_op(i, a, b);
    wait_done(i, lat);
    d  = d_s[i];
    br = bo_s[i];
    finish_op(i, stall);
  endtask

  task automatic run_random(input int i, input int nops);
    int          lat;
    logic [63:0] d, a, b;
    logic        br;
    for (int k = 0; k < nops; k++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0: b = a;
        1: begin a = 64'd0; b = 64'd1; end
        2: begin a = 64'd0; b = '1; end
        3: begin a = '1; b = 64'd0; end
        default: ;
      endcase
      dr_s[i] = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      do_op(i, a, b, $urandom_range(0, 4), lat, d, br);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat, n;
    logic [63:0] d;
    logic        br;

    for (int g = 0; g < NI; g++) begin
      rst_s[g] = 1'b0;
      sv_s[g]  = 1'b0;
      dr_s[g]  = 1'b0;
      a_s[g]   = '0;
      b_s[g]   = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("reset_start_ready", 64'(rdy_s[0]), 64'd1);
    check("reset_done_valid", 64'(dv_s[0]), 64'd0);
    check("reset_diff", d_s[0], 64'd0);
    check("reset_borrow", 64'(bo_s[0]), 64'd0);
    for (int g = 0; g < NI; g++) rst_s[g] = 1'b1;
    go = 1'b1;

    do_op(0, 64'h5A, 64'h3C, 0, lat, d, br);
    check("t1_latency", 64'(lat), 64'd8);
    check("t1_diff", d, 64'h1E);
    check("t1_borrow", 64'(br), 64'd0);

    do_op(0, 64'h00, 64'h01, 0, lat, d, br);
    check("t2a_diff", d, 64'hFF);
    check("t2a_borrow", 64'(br), 64'd1);
    do_op(0, 64'hFF, 64'hFF, 1, lat, d, br);
    check("t2b_diff", d, 64'h00);
    check("t2b_borrow", 64'(br), 64'd0);

    start_op(0, 64'h10, 64'h20);
    wait_done(0, lat);
    dr_s[0] = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      check("t3_stall_valid", 64'(dv_s[0]), 64'd1);
      check("t3_stall_diff", d_s[0], 64'hF0);
      check("t3_stall_borrow", 64'(bo_s[0]), 64'd1);
    end
    dr_s[0] = 1'b1;
    @(posedge clk); #1;
    dr_s[0] = 1'b0;
    check("t3_release_valid", 64'(dv_s[0]), 64'd0);
    check("t3_release_ready", 64'(rdy_s[0]), 64'd1);
    check("t3_retained_diff", d_s[0], 64'hF0);
    check("t3_retained_borrow", 64'(bo_s[0]), 64'd1);

    start_op(0, 64'h3C, 64'h5A);
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_s[0] = 1'b0;
    #1;
    check("t5_reset_valid", 64'(dv_s[0]), 64'd0);
    check("t5_reset_ready", 64'(rdy_s[0]), 64'd1);
    check("t5_reset_diff", d_s[0], 64'd0);
    check("t5_reset_borrow", 64'(bo_s[0]), 64'd0);
    @(posedge clk); #1;
    rst_s[0] = 1'b1;
    do_op(0, 64'h03, 64'h05, 0, lat, d, br);
    check("t5_next_diff", d, 64'hFE);
    check("t5_next_borrow", 64'(br), 64'd1);

    fork
      do_op(0, 64'h80, 64'h01, 0, lat, d, br);
      begin
        repeat (3) @(posedge clk);
        #2;
        a_s[0]  = 64'h77;
        b_s[0]  = 64'h11;
        sv_s[0] = 1'b1;
        check("t4_ready_in_run", 64'(rdy_s[0]), 64'd0);
        @(posedge clk); #1;
        sv_s[0] = 1'b0;
      end
    join
    check("t4_diff", d, 64'h7F);
    check("t4_borrow", 64'(br), 64'd0);

    run_random(0, 250);

    n = 0;
    while (!(g_inst[1].fin && g_inst[2].fin && g_inst[3].fin) && n < 60000) begin
      @(posedge clk);
      n++;
    end
    if (!(g_inst[1].fin && g_inst[2].fin && g_inst[3].fin)) timeout("random_instances_finish");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
